// File: rtl/fp_wb_arbiter.sv
// rtl/fp_wb_arbiter.sv - round-robin FP register-file write-port arbiter with pending-write scoreboard
//
// Shares the single write port of the 32-entry FP register file between the
// FPU result (0), the LWC1 load return (1) and the MTC1 move (2).
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   req_valid/ready     per-requester handshake (ready is a one-hot grant)
//   req_reg/req_data    per-requester destination index and result, packed by index
//   FP_RegWrite,
//   WriteReg, WriteData registered register-file write port
//   sb_set, sb_set_reg  dispatch marks a destination as pending
//   q1/q2_reg, _busy    issue-stage hazard queries (combinational)
//   waw_err, stray_err  sticky protocol error flags

module fp_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREQ   = 3    // fixed at 3: the rotation table below assumes it
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_reg,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic                     FP_RegWrite,
    output logic [ADDR_W-1:0]        WriteReg,
    output logic [DATA_W-1:0]        WriteData,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_set_reg,
    input  logic [ADDR_W-1:0]        q1_reg,
    input  logic [ADDR_W-1:0]        q2_reg,
    output logic                     q1_busy,
    output logic                     q2_busy,
    output logic                     waw_err,
    output logic                     stray_err
);

    localparam int NREG = 1 << ADDR_W;

    logic [1:0]        last;
    logic [1:0]        order [3];
    logic              gnt_any;
    logic [1:0]        gnt_idx;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;

    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   clr_mask;
    logic [NREG-1:0]   pending_nxt;
    logic              waw_hit;
    logic              stray_hit;

    // Search order starts just after the most recently granted requester.
    always_comb begin
        case (last)
            2'd0:    order = '{2'd1, 2'd2, 2'd0};
            2'd1:    order = '{2'd2, 2'd0, 2'd1};
            default: order = '{2'd0, 2'd1, 2'd2};
        endcase
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && req_valid[order[k]]) begin
                gnt_any = 1'b1;
                gnt_idx = order[k];
            end
        end
    end

    // Grant is suppressed combinationally during reset so no requester
    // believes it was accepted while the write port is being cleared.
    always_comb begin
        req_ready = '0;
        if (rst && gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == 2'(k)) begin
                sel_reg  = req_reg[k*ADDR_W +: ADDR_W];
                sel_data = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= 2'd2;
        end else if (gnt_any) begin
            last <= gnt_idx;
        end
    end

    // Registered write port; index and data hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            FP_RegWrite <= 1'b0;
            WriteReg    <= '0;
            WriteData   <= '0;
        end else begin
            FP_RegWrite <= gnt_any;
            if (gnt_any) begin
                WriteReg  <= sel_reg;
                WriteData <= sel_data;
            end
        end
    end

    // Set is applied after clear so a fresh producer on the register being
    // committed keeps it pending.
    always_comb begin
        set_mask    = sb_set      ? (NREG'(1) << sb_set_reg) : '0;
        clr_mask    = FP_RegWrite ? (NREG'(1) << WriteReg)   : '0;
        pending_nxt = (pending & ~clr_mask) | set_mask;
    end

    // A re-issue to a register whose write lands on this same edge is the
    // normal back-to-back case, not a WAW violation.
    always_comb begin
        waw_hit   = sb_set && pending[sb_set_reg]
                    && !(FP_RegWrite && (WriteReg == sb_set_reg));
        stray_hit = FP_RegWrite && !pending[WriteReg];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending   <= '0;
            waw_err   <= 1'b0;
            stray_err <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (waw_hit) begin
                waw_err <= 1'b1;
            end
            if (stray_hit) begin
                stray_err <= 1'b1;
            end
        end
    end

    // No bypass: a register committing this cycle still reads busy.
    assign q1_busy = pending[q1_reg];
    assign q2_busy = pending[q2_reg];

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb/tb_fp_wb_arbiter.sv - self-checking bench for fp_wb_arbiter

module tb_fp_wb_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_reg;
    logic [95:0] req_data;
    logic        FP_RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        sb_set;
    logic [4:0]  sb_set_reg;
    logic [4:0]  q1_reg;
    logic [4:0]  q2_reg;
    logic        q1_busy;
    logic        q2_busy;
    logic        waw_err;
    logic        stray_err;

    logic [4:0]  vreg  [3];
    logic [31:0] vdata [3];

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q [$];
    logic [4:0]  exp_wreg;
    logic [31:0] exp_wdata;
    int          passed;
    int          total;

    assign req_reg  = {vreg[2], vreg[1], vreg[0]};
    assign req_data = {vdata[2], vdata[1], vdata[0]};

    fp_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_reg     (req_reg),
        .req_data    (req_data),
        .FP_RegWrite (FP_RegWrite),
        .WriteReg    (WriteReg),
        .WriteData   (WriteData),
        .sb_set      (sb_set),
        .sb_set_reg  (sb_set_reg),
        .q1_reg      (q1_reg),
        .q2_reg      (q2_reg),
        .q1_busy     (q1_busy),
        .q2_busy     (q2_busy),
        .waw_err     (waw_err),
        .stray_err   (stray_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Checks the grant for the current inputs, queues the expected write,
    // then crosses one rising edge and checks the write port.
    task automatic tick(input int exp_gnt);
        logic [2:0] exp_rdy;
        wr_t        e;
        exp_rdy = (exp_gnt < 0) ? 3'b000 : (3'b001 << exp_gnt);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (exp_gnt >= 0) begin
            e.r = vreg[exp_gnt];
            e.d = vdata[exp_gnt];
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wen", 32'(FP_RegWrite), 32'd1);
            chk("wreg", 32'(WriteReg), 32'(e.r));
            chk("wdata", WriteData, e.d);
            exp_wreg  = e.r;
            exp_wdata = e.d;
        end else begin
            chk("wen_idle", 32'(FP_RegWrite), 32'd0);
            chk("wreg_hold", 32'(WriteReg), 32'(exp_wreg));
            chk("wdata_hold", WriteData, exp_wdata);
        end
    endtask

    // Asserts reset mid-cycle and checks that every output clears at once.
    task automatic do_reset();
        #2;
        rst       = 1'b0;
        req_valid = 3'b111;
        sb_set    = 1'b0;
        #1;
        chk("rst_wen", 32'(FP_RegWrite), 32'd0);
        chk("rst_wreg", 32'(WriteReg), 32'd0);
        chk("rst_wdata", WriteData, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_waw", 32'(waw_err), 32'd0);
        chk("rst_stray", 32'(stray_err), 32'd0);
        chk("rst_q1", 32'(q1_busy), 32'd0);
        chk("rst_q2", 32'(q2_busy), 32'd0);
        req_valid = 3'b000;
        exp_q.delete();
        exp_wreg  = '0;
        exp_wdata = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        rst        = 1'b0;
        req_valid  = 3'b000;
        sb_set     = 1'b0;
        sb_set_reg = '0;
        q1_reg     = '0;
        q2_reg     = '0;
        exp_wreg   = '0;
        exp_wdata  = '0;
        for (int i = 0; i < 3; i++) begin
            vreg[i]  = 5'(i + 1);
            vdata[i] = 32'hA000_0000 + 32'(i);
        end

        do_reset();

        // Full contention: 0,1,2,0,1,2 with a write every cycle.
        req_valid = 3'b111;
        #1;
        tick(0); tick(1); tick(2); tick(0); tick(1); tick(2);
        chk("wen_before_reset", 32'(FP_RegWrite), 32'd1);

        // Reset while a write is in flight.
        do_reset();

        // First contention after reset goes to requester 0.
        req_valid = 3'b111; #1; tick(0);
        req_valid = 3'b110; #1; tick(1);
        req_valid = 3'b100; #1; tick(2);
        // Put last at 0, idle one cycle (pointer holds), then skip requester 1.
        req_valid = 3'b001; #1; tick(0);
        req_valid = 3'b000; #1; tick(-1);
        req_valid = 3'b101; #1;
        tick(2); tick(0); tick(2); tick(0);
        req_valid = 3'b100; #1; tick(2);
        req_valid = 3'b000; #1; tick(-1);

        do_reset();

        // Scoreboard lifecycle on register 7.
        q1_reg     = 5'd7;
        q2_reg     = 5'd8;
        sb_set     = 1'b1;
        sb_set_reg = 5'd7;
        #1;
        chk("life_c0_busy", 32'(q1_busy), 32'd0);
        tick(-1);
        sb_set = 1'b0;
        #1;
        chk("life_c1_busy", 32'(q1_busy), 32'd1);
        chk("life_c1_q2", 32'(q2_busy), 32'd0);
        tick(-1);
        #1;
        chk("life_c2_busy", 32'(q1_busy), 32'd1);
        tick(-1);
        vreg[0]   = 5'd7;
        vdata[0]  = 32'h3F80_0000;
        req_valid = 3'b001;
        #1;
        chk("life_c3_busy", 32'(q1_busy), 32'd1);
        tick(0);
        req_valid = 3'b000;
        #1;
        chk("life_c4_busy", 32'(q1_busy), 32'd1);
        tick(-1);
        #1;
        chk("life_c5_busy", 32'(q1_busy), 32'd0);
        chk("life_waw", 32'(waw_err), 32'd0);
        chk("life_stray", 32'(stray_err), 32'd0);

        // Simultaneous set/clear on register 9.
        q1_reg     = 5'd9;
        sb_set     = 1'b1;
        sb_set_reg = 5'd9;
        #1;
        tick(-1);
        sb_set    = 1'b0;
        vreg[0]   = 5'd9;
        vdata[0]  = 32'h1234_5678;
        req_valid = 3'b001;
        #1;
        tick(0);
        req_valid = 3'b000;
        sb_set    = 1'b1;
        #1;
        chk("sim_commit_busy", 32'(q1_busy), 32'd1);
        tick(-1);
        #1;
        chk("sim_pending_kept", 32'(q1_busy), 32'd1);
        chk("sim_waw_clear", 32'(waw_err), 32'd0);
        chk("sim_stray_clear", 32'(stray_err), 32'd0);
        tick(-1);
        sb_set = 1'b0;
        #1;
        chk("sim_waw_set", 32'(waw_err), 32'd1);
        chk("sim_still_busy", 32'(q1_busy), 32'd1);

        do_reset();

        // Stray write: LWC1 commits register 12 that was never marked pending.
        vreg[1]   = 5'd12;
        vdata[1]  = 32'hDEAD_BEEF;
        req_valid = 3'b010;
        #1;
        tick(1);
        req_valid = 3'b000;
        #1;
        chk("stray_commit_cycle", 32'(stray_err), 32'd0);
        tick(-1);
        #1;
        chk("stray_set", 32'(stray_err), 32'd1);
        tick(-1);
        tick(-1);
        chk("stray_sticky", 32'(stray_err), 32'd1);
        chk("stray_no_waw", 32'(waw_err), 32'd0);

        do_reset();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fp_wb_arbiter.md
# fp_wb_arbiter

Shares the single write port of the 32-entry floating-point register file between three result producers: FPU arithmetic result, LWC1 load return and MTC1 move. Producers use a valid/ready handshake. Grants rotate round-robin, and the winning result is registered onto the register-file write port. A 32-bit pending-write scoreboard records FP destinations that dispatch has issued but writeback has not yet committed. The issue stage uses it to stall RAW/WAW hazards.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register index width (32 registers)
- NREQ, 3, number of requesters; fixed: 0=FPU, 1=LWC1, 2=MTC1

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset: rst=0 resets immediately, deassertion sampled on clk
- req_valid  input  NREQ  requester i has a result
- req_ready  output  NREQ  grant to requester i this cycle
- req_reg  input  NREQ*ADDR_W  destination index; requester i in bits [i*5+4:i*5]
- req_data  input  NREQ*DATA_W  result data; requester i in bits [i*32+31:i*32]
- FP_RegWrite  output  1  register-file write enable (registered)
- WriteReg  output  ADDR_W  register-file write index (registered)
- WriteData  output  DATA_W  register-file write data (registered)
- sb_set  input  1  dispatch issued an instruction with an FP destination
- sb_set_reg  input  ADDR_W  that destination
- q1_reg, q2_reg  input  ADDR_W  source indices queried by issue
- q1_busy, q2_busy  output  1  queried register has a pending write (combinational)
- waw_err  output  1  sticky: sb_set targeted an already-pending register
- stray_err  output  1  sticky: a write committed to a non-pending register

## Operation
- **Handshake.** Transfer occurs when req_valid[i] & req_ready[i].
  - Requester holds valid, reg and data stable until accepted.
  - Valid may not be withdrawn before acceptance.
- **Grant.**
  - At most one req_ready bit is high per cycle, and only for a requester with valid high.
  - req_ready is combinational from req_valid and the priority pointer.
  - req_ready is forced 0 while rst=0.
- **Round-robin.**
  - Pointer `last` (2 bits, values 0..2) holds the most recently granted requester.
  - Search order: last+1, last+2, last+3 (mod 3).
  - On a grant, `last` takes the granted index; with no grant it holds.
  - Reset value of `last` is 2, so requester 0 has first priority.
- **Write port.**
  - On a transfer, the next edge loads FP_RegWrite=1, WriteReg=req_reg[g], WriteData=req_data[g].
  - With no transfer, FP_RegWrite=0 and WriteReg/WriteData hold their previous values.
- **Scoreboard.** pending[31:0].
  - Set: sb_set=1 sets pending[sb_set_reg] at the edge.
  - Clear: FP_RegWrite=1 clears pending[WriteReg] at the edge, i.e. when the write lands in the register file.
  - Set and clear of the same index in the same cycle: set wins and the bit stays 1, because a new producer supersedes the old one.
  - Set and clear of different indices in the same cycle are both applied.
- **Query.**
  - qN_busy = pending[qN_reg]; no bypass.
  - A register being written this cycle still reads busy.
  - It reads free from the cycle after the commit edge.
- **Errors.**
  - waw_err sets when sb_set=1 and pending[sb_set_reg]=1 before the update, unless that same edge also clears sb_set_reg.
  - stray_err sets when FP_RegWrite=1 and pending[WriteReg]=0.
  - Both flags are sticky until reset.

## Timing
- **Reset values:**
  - FP_RegWrite=0, WriteReg=0, WriteData=0
  - pending=0, last=2
  - waw_err=0, stray_err=0, req_ready=0
- **Write-port latency:** 1 cycle. A transfer in cycle N writes the register file at the end of cycle N+1.
- **Scoreboard release:** pending clears at the end of cycle N+1; qN_busy reads 0 from cycle N+2.
- **Throughput:** one write per cycle, sustained. Under full contention each requester is granted every 3rd cycle. Maximum wait from valid to grant is 2 cycles.
- **Reset mid-operation:**
  - An in-flight registered write is dropped (FP_RegWrite forced 0).
  - The scoreboard is cleared.
  - Requesters must re-present after reset deasserts.
- No combinational path from req_* to FP_RegWrite, WriteReg or WriteData.

## Test plan
- **Reset:** assert rst=0 mid-cycle with FP_RegWrite=1 -> all outputs 0 immediately. After release, first contention with valid=3'b111 grants requester 0.
- **Full contention:** valid=3'b111 held for 6 cycles -> grant order 0,1,2,0,1,2. Write port shows the matching req_reg/req_data one cycle later, with FP_RegWrite=1 every cycle.
- **Skip idle requesters:** valid=3'b101 after last=0 -> grants 2,0,2,0. Requester 1 is never granted and `last` never equals 1.
- **Scoreboard lifecycle:**
  - Stimulus: sb_set reg 7 in cycle 0; FPU transfer to reg 7 with data 32'h3F800000 in cycle 3; q1_reg=7 throughout.
  - Response: q1_busy=1 in cycles 1..4; write of 32'h3F800000 to reg 7 in cycle 4; q1_busy=0 in cycle 5.
  - Both error flags stay 0.
- **Simultaneous set/clear:** sb_set reg 9 in the same cycle FP_RegWrite commits reg 9 -> pending[9] stays 1 and waw_err stays 0. sb_set reg 9 again next cycle -> waw_err=1.
- **Stray write:** LWC1 writes reg 12 with no prior sb_set -> stray_err=1 the cycle after the commit and remains 1 until reset.
